ex_mem_stage_reg: RTL

//  Execute->Memory boundary of the pipelined core. Holds the architectural NZCV flag register that feeds

---
 rtl/ex_mem_stage_reg_pkg.sv | 30 +++
 rtl/ex_mem_stage_reg_nzcv_flag_reg.sv | 24 ++
 rtl/ex_mem_stage_reg.sv | 119 +++++++++++
 3 files changed

// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared definitions for the Execute->Memory stage register: NZCV bit positions,
// FlagWr enable bit meanings, and the bubble/reset image of the M-stage controls.
// No ports; imported by ex_mem_stage_reg and ex_mem_stage_reg_nzcv_flag_reg.
package ex_mem_stage_reg_pkg;

  // NZCV bit positions within the 4-bit flag word {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagWr bit meanings: [1] writes the N,Z half, [0] writes the C,V half
  localparam int FLAGWR_NZ = 1;
  localparam int FLAGWR_CV = 0;

  localparam logic [3:0] NZCV_RESET = 4'b0000;

  // M-stage control bundle; a bubble is all-zero, which is also the reset image
  typedef struct packed {
    logic valid;
    logic pcsrc;
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic branch_taken;
  } m_ctrl_t;

  localparam m_ctrl_t M_CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_stage_reg_nzcv_flag_reg.sv
// Architectural NZCV register with independent N,Z and C,V half-enables.
// Latency: a written half is visible on q the cycle after the enabling edge.
// Ports: clk, rst (sync, active-high), en_nz, en_cv, d[3:0] = {N,Z,C,V}, q[3:0].
module ex_mem_stage_reg_nzcv_flag_reg
  import ex_mem_stage_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_nz,
  input  logic       en_cv,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= NZCV_RESET;
    end else begin
      if (en_nz) q[FLAG_N:FLAG_Z] <= d[FLAG_N:FLAG_Z];
      if (en_cv) q[FLAG_C:FLAG_V] <= d[FLAG_C:FLAG_V];
    end
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// Execute->Memory pipeline register plus the NZCV flag register fed back to the E-stage condition check.
// Latency: 1 cycle E->M for every captured field; flag writes visible on FlagsE one cycle after accept.
// Stall: StallM freezes M, flags and counters; KillE or ~ValidE inserts a bubble (controls 0, data held).
// Ports: sys_clk, sys_rst_n (sync, active-HIGH despite the name), StallM/KillE/ValidE/CondExE hazard
//   and qualifier inputs, E-stage controls and data in; FlagsE, M-stage controls/data, CntAnnul/CntBranch out.
// Optional: define EXM_PERF_CNT_EN to build the retire-side annul/branch counters; otherwise they read 0.
module ex_mem_stage_reg
  import ex_mem_stage_reg_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 4
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           StallM,
  input  logic           KillE,
  input  logic           ValidE,
  input  logic           CondExE,
  input  logic           PCSrc,
  input  logic           RegWrite,
  input  logic           MemWrite,
  input  logic           MemtoRegE,
  input  logic           BranchTakenE,
  input  logic [1:0]     FlagWr,
  input  logic [3:0]     Flags_in,
  input  logic [DW-1:0]  ALUResultE,
  input  logic [DW-1:0]  WriteDataE,
  input  logic [RAW-1:0] WA3E,
  output logic [3:0]     FlagsE,
  output logic           ValidM,
  output logic           PCSrcM,
  output logic           RegWriteM,
  output logic           MemWriteM,
  output logic           MemtoRegM,
  output logic           BranchTakenM,
  output logic [DW-1:0]  ALUOutM,
  output logic [DW-1:0]  WriteDataM,
  output logic [RAW-1:0] WA3M,
  output logic [DW-1:0]  CntAnnul,
  output logic [DW-1:0]  CntBranch
);

  logic    accept;
  m_ctrl_t ctrl_e;
  m_ctrl_t ctrl_q;

  assign accept = ValidE & ~KillE & ~StallM;

  assign ctrl_e = '{valid:        1'b1,
                    pcsrc:        PCSrc,
                    regwrite:     RegWrite,
                    memwrite:     MemWrite,
                    memtoreg:     MemtoRegE,
                    branch_taken: BranchTakenE};

  // FlagWr arrives already qualified by the condition check; only accept gates it here
  ex_mem_stage_reg_nzcv_flag_reg u_nzcv (
    .clk   (sys_clk),
    .rst   (sys_rst_n),
    .en_nz (accept & FlagWr[FLAGWR_NZ]),
    .en_cv (accept & FlagWr[FLAGWR_CV]),
    .d     (Flags_in),
    .q     (FlagsE)
  );

  // Controls collapse to a bubble when nothing is accepted; data fields just hold
  // because a bubble never consumes them.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      ctrl_q     <= M_CTRL_BUBBLE;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else if (!StallM) begin
      if (accept) begin
        ctrl_q     <= ctrl_e;
        ALUOutM    <= ALUResultE;
        WriteDataM <= WriteDataE;
        WA3M       <= WA3E;
      end else begin
        ctrl_q     <= M_CTRL_BUBBLE;
      end
    end
  end

  assign ValidM       = ctrl_q.valid;
  assign PCSrcM       = ctrl_q.pcsrc;
  assign RegWriteM    = ctrl_q.regwrite;
  assign MemWriteM    = ctrl_q.memwrite;
  assign MemtoRegM    = ctrl_q.memtoreg;
  assign BranchTakenM = ctrl_q.branch_taken;

`ifdef EXM_PERF_CNT_EN
  logic [DW-1:0] cnt_annul_q;
  logic [DW-1:0] cnt_branch_q;

  // accept already excludes stall, so the counters hold whenever M holds; natural wrap at 2^DW
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      cnt_annul_q  <= '0;
      cnt_branch_q <= '0;
    end else if (accept) begin
      cnt_annul_q  <= cnt_annul_q  + {{(DW-1){1'b0}}, ~CondExE};
      cnt_branch_q <= cnt_branch_q + {{(DW-1){1'b0}}, BranchTakenE};
    end
  end

  assign CntAnnul  = cnt_annul_q;
  assign CntBranch = cnt_branch_q;
`else
  // CondExE only feeds the annul counter, which is absent in this build
  logic unused_cond_ex;
  assign unused_cond_ex = CondExE;

  assign CntAnnul  = '0;
  assign CntBranch = '0;
`endif

endmodule
